// File: rtl/rasterizer_vertex_fetch_multi.sv
// Vertex fetch engine: pipelined Avalon-MM word reads assembled into WORDS-word vertices,
// delivered in order through a first-word-fall-through FIFO. Optional VFETCH_PERF_CNT_EN adds perf counters.
module rasterizer_vertex_fetch_multi #(
  parameter int ADDR_W          = 26,
  parameter int DATA_W          = 32,
  parameter int WORDS           = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_W           = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic [ADDR_W-1:0]       master_address,
  output logic                    master_read,
  output logic                    master_write,
  output logic [DATA_W/8-1:0]     master_byteenable,
  output logic [DATA_W-1:0]       master_writedata,
  input  logic [DATA_W-1:0]       master_readdata,
  input  logic                    master_readdatavalid,
  input  logic                    master_waitrequest,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [CNT_W-1:0]        cmd_count,
  output logic                    vtx_valid,
  input  logic                    vtx_ready,
  output logic [WORDS*DATA_W-1:0] vtx_data,
  output logic                    vtx_last,
  output logic                    busy,
  output logic [1:0]              fsm_state
`ifdef VFETCH_PERF_CNT_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             vtx_fetched
`endif
);
  // Handshakes: a transfer happens on the rising edge where valid & ready (Avalon: read & !waitrequest);
  // an offered item (read request, vertex) is held unchanged until it is taken.

  localparam int VTX_W = WORDS * DATA_W;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int RES_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [OUT_W-1:0]  MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [RES_W-1:0]  RES_MAX   = RES_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  issue_left;
  logic [CNT_W-1:0]  push_left;
  logic [IDX_W-1:0]  issue_idx;
  logic [IDX_W-1:0]  asm_idx;
  logic [OUT_W-1:0]  outstanding;
  logic [RES_W-1:0]  reserved;
  logic [VTX_W-1:0]  asm_vec;
  logic [VTX_W-1:0]  push_data;
  logic [VTX_W:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;

  logic accept, first_accept, ret, push, pop, fifo_empty;

  // Request is a pure function of registered state; outstanding and reserved can only
  // fall while a request waits, so an offered read never gets withdrawn.
  assign master_read       = (state == S_ISSUE) && (outstanding < MAX_OUT) &&
                             ((issue_idx != '0) || (reserved < RES_MAX));
  assign master_address    = addr_q;
  assign master_write      = 1'b0;
  assign master_byteenable = '1;
  assign master_writedata  = '0;

  assign accept       = master_read & ~master_waitrequest;
  assign first_accept = accept & (issue_idx == '0);
  assign ret          = master_readdatavalid & (outstanding != '0);
  assign push         = ret & (asm_idx == LAST_IDX);
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign vtx_valid    = ~fifo_empty;
  assign pop          = vtx_valid & vtx_ready;
  assign {vtx_last, vtx_data} = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign cmd_ready    = (state == S_IDLE);
  assign busy         = (state != S_IDLE) | ~fifo_empty;
  assign fsm_state    = state;

  always_comb begin
    push_data = asm_vec;
    push_data[(WORDS-1)*DATA_W +: DATA_W] = master_readdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      issue_left  <= '0;
      push_left   <= '0;
      issue_idx   <= '0;
      asm_idx     <= '0;
      outstanding <= '0;
      reserved    <= '0;
      asm_vec     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && (cmd_count != '0)) begin
            addr_q     <= cmd_addr;
            issue_left <= cmd_count;
            push_left  <= cmd_count;
            issue_idx  <= '0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (accept) begin
            addr_q <= addr_q + ADDR_STEP;
            if (issue_idx == LAST_IDX) begin
              issue_idx  <= '0;
              issue_left <= issue_left - CNT_ONE;
              if (issue_left == CNT_ONE) state <= S_DRAIN;
            end else begin
              issue_idx <= issue_idx + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if ((outstanding == '0) && (push_left == '0)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (accept && !ret)      outstanding <= outstanding + 1'b1;
      else if (!accept && ret) outstanding <= outstanding - 1'b1;

      // One FIFO slot per vertex in flight, claimed by its first read, freed by its pop.
      if (first_accept && !pop)      reserved <= reserved + 1'b1;
      else if (!first_accept && pop) reserved <= reserved - 1'b1;

      if (ret) begin
        if (asm_idx == LAST_IDX) begin
          asm_idx   <= '0;
          push_left <= push_left - CNT_ONE;
        end else begin
          asm_vec[asm_idx*DATA_W +: DATA_W] <= master_readdata;
          asm_idx <= asm_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr[PTR_W-1:0]] <= {(push_left == CNT_ONE), push_data};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef VFETCH_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      vtx_fetched  <= '0;
    end else begin
      if (master_read && master_waitrequest && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (push && (vtx_fetched != '1)) vtx_fetched <= vtx_fetched + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rasterizer_vertex_fetch_multi.sv
// Directed bench for rasterizer_vertex_fetch_multi with a 2-cycle-latency Avalon memory model
// (word at A = A ^ 32'hA5A5_0000) and an optional stall window on one address.
module tb_rasterizer_vertex_fetch_multi;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int VTX_W  = 96;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] master_address;
  logic              master_read, master_write;
  logic [3:0]        master_byteenable;
  logic [DATA_W-1:0] master_writedata;
  logic [DATA_W-1:0] master_readdata;
  logic              master_readdatavalid;
  logic              master_waitrequest;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [CNT_W-1:0]  cmd_count = '0;
  logic              vtx_valid;
  logic              vtx_ready = 1'b0;
  logic [VTX_W-1:0]  vtx_data;
  logic              vtx_last;
  logic              busy;
  logic [1:0]        fsm_state;
`ifdef VFETCH_PERF_CNT_EN
  logic [31:0]       stall_cycles, vtx_fetched;
`endif

  int checks = 0;
  int errors = 0;

  rasterizer_vertex_fetch_multi dut (
    .clock(clock), .reset(reset),
    .master_address(master_address), .master_read(master_read), .master_write(master_write),
    .master_byteenable(master_byteenable), .master_writedata(master_writedata),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .vtx_valid(vtx_valid), .vtx_ready(vtx_ready), .vtx_data(vtx_data), .vtx_last(vtx_last),
    .busy(busy), .fsm_state(fsm_state)
`ifdef VFETCH_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .vtx_fetched(vtx_fetched)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory slave model ----------------
  function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a);
    return {6'd0, a} ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [VTX_W-1:0] exp_vtx(input logic [ADDR_W-1:0] a);
    return {word_at(a + ADDR_W'(8)), word_at(a + ADDR_W'(4)), word_at(a)};
  endfunction

  logic [ADDR_W-1:0] pend_q[$];
  logic              rv_q;
  logic [DATA_W-1:0] rd_q;
  logic              inject_rv  = 1'b0;
  logic              stall_arm  = 1'b0;
  logic [ADDR_W-1:0] stall_addr = '0;
  int                stall_end  = 0;
  int                wait_count = 0;

  assign master_readdatavalid = rv_q | inject_rv;
  assign master_readdata      = rd_q;
  assign master_waitrequest   = stall_arm && master_read && (master_address == stall_addr) &&
                                (wait_count < stall_end);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q.delete();
      rv_q <= 1'b0;
      rd_q <= '0;
    end else begin
      if (pend_q.size() != 0) begin
        rv_q <= 1'b1;
        rd_q <= word_at(pend_q.pop_front());
      end else begin
        rv_q <= 1'b0;
      end
      if (master_read && !master_waitrequest) pend_q.push_back(master_address);
    end
  end

  // ---------------- bus / vertex monitor ----------------
  logic [ADDR_W-1:0] addr_log[$];
  logic [VTX_W:0]    got_log[$];
  int                acc_n = 0, rd_cycles = 0, vv_cycles = 0, hold_viol = 0, stable_viol = 0;
  logic              prev_wait = 1'b0, prev_hold_v = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [VTX_W:0]    prev_vtx = '0;

  always @(posedge clock) begin
    if (master_read && !master_waitrequest) begin
      acc_n <= acc_n + 1;
      addr_log.push_back(master_address);
    end
    if (master_read) rd_cycles <= rd_cycles + 1;
    if (master_read && master_waitrequest) wait_count <= wait_count + 1;
    if (vtx_valid) vv_cycles <= vv_cycles + 1;
    if (vtx_valid && vtx_ready) got_log.push_back({vtx_last, vtx_data});
    if (prev_wait && (!master_read || master_address != prev_addr)) hold_viol <= hold_viol + 1;
    if (prev_hold_v && (!vtx_valid || {vtx_last, vtx_data} != prev_vtx)) stable_viol <= stable_viol + 1;
    prev_wait   <= master_read && master_waitrequest;
    prev_addr   <= master_address;
    prev_hold_v <= vtx_valid && !vtx_ready;
    prev_vtx    <= {vtx_last, vtx_data};
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset     = 1'b0;
    cmd_valid = 1'b0;
    vtx_ready = 1'b0;
    inject_rv = 1'b0;
    stall_arm = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
    int t = 0;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_count = n;
    while (!cmd_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_handshake: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, t);
    end
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    @(negedge clock);
    while (busy && t < budget) begin
      @(negedge clock);
      t++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, t);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (master_read !== 1'b0) begin errors++; $display("FAIL rst_read: got %0b exp 0", master_read); end
    checks++; if (master_address !== '0) begin errors++; $display("FAIL rst_addr: got %0h exp 0", master_address); end
    checks++; if (vtx_valid !== 1'b0) begin errors++; $display("FAIL rst_vtx_valid: got %0b exp 0", vtx_valid); end
    checks++; if (vtx_data !== '0) begin errors++; $display("FAIL rst_vtx_data: got %0h exp 0", vtx_data); end
    checks++; if (vtx_last !== 1'b0) begin errors++; $display("FAIL rst_vtx_last: got %0b exp 0", vtx_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b exp 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %0b exp 1", cmd_ready); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", fsm_state); end
    checks++; if (master_write !== 1'b0 || master_byteenable !== 4'hF || master_writedata !== '0) begin
      errors++; $display("FAIL rst_tieoffs: got w=%0b be=%0h wd=%0h exp 0 f 0", master_write, master_byteenable, master_writedata);
    end
  endtask

  task automatic test_single();
    int ba = addr_log.size();
    int bg = got_log.size();
    vtx_ready = 1'b1;
    send_cmd(ADDR_W'('h100), 16'd1);
    wait_idle(200);
    checks++; if (addr_log.size() - ba !== 3) begin errors++; $display("FAIL single_reads: got %0d exp 3", addr_log.size() - ba); end
    for (int k = 0; k < 3; k++) begin
      if (addr_log.size() > ba + k) begin
        checks++;
        if (addr_log[ba+k] !== ADDR_W'('h100 + 4*k)) begin
          errors++; $display("FAIL single_addr%0d: got %0h exp %0h", k, addr_log[ba+k], 'h100 + 4*k);
        end
      end
    end
    checks++; if (got_log.size() - bg !== 1) begin errors++; $display("FAIL single_vtx_count: got %0d exp 1", got_log.size() - bg); end
    if (got_log.size() > bg) begin
      checks++; if (got_log[bg] !== {1'b1, exp_vtx(ADDR_W'('h100))}) begin
        errors++; $display("FAIL single_vtx: got %0h exp %0h", got_log[bg], {1'b1, exp_vtx(ADDR_W'('h100))});
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %0b exp 0", busy); end
  endtask

  task automatic test_stall();
    int ba, bg, bw, bh;
    do_reset();
    ba = addr_log.size(); bg = got_log.size(); bw = wait_count; bh = hold_viol;
    vtx_ready  = 1'b1;
    stall_addr = ADDR_W'('h104);
    stall_end  = wait_count + 5;
    stall_arm  = 1'b1;
    send_cmd(ADDR_W'('h100), 16'd1);
    wait_idle(200);
    stall_arm = 1'b0;
    checks++; if (wait_count - bw !== 5) begin errors++; $display("FAIL stall_len: got %0d exp 5", wait_count - bw); end
    checks++; if (hold_viol - bh !== 0) begin errors++; $display("FAIL stall_hold: got %0d violations exp 0", hold_viol - bh); end
    checks++; if (addr_log.size() - ba !== 3) begin errors++; $display("FAIL stall_reads: got %0d exp 3", addr_log.size() - ba); end
    if (addr_log.size() > ba + 2) begin
      checks++; if (addr_log[ba+1] !== ADDR_W'('h104) || addr_log[ba+2] !== ADDR_W'('h108)) begin
        errors++; $display("FAIL stall_addr: got %0h %0h exp 104 108", addr_log[ba+1], addr_log[ba+2]);
      end
    end
    checks++; if (got_log.size() - bg !== 1) begin errors++; $display("FAIL stall_vtx_count: got %0d exp 1", got_log.size() - bg); end
    if (got_log.size() > bg) begin
      checks++; if (got_log[bg] !== {1'b1, exp_vtx(ADDR_W'('h100))}) begin
        errors++; $display("FAIL stall_vtx: got %0h exp %0h", got_log[bg], {1'b1, exp_vtx(ADDR_W'('h100))});
      end
    end
`ifdef VFETCH_PERF_CNT_EN
    checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL perf_stall: got %0d exp 5", stall_cycles); end
    checks++; if (vtx_fetched !== 32'd1) begin errors++; $display("FAIL perf_fetched: got %0d exp 1", vtx_fetched); end
`endif
  endtask

  task automatic test_backpressure();
    int ba = addr_log.size();
    int bg = got_log.size();
    int bs = stable_viol;
    logic [ADDR_W-1:0] va;
    vtx_ready = 1'b0;
    send_cmd(ADDR_W'('h200), 16'd8);
    repeat (40) @(negedge clock);
    checks++; if (addr_log.size() - ba !== 12) begin errors++; $display("FAIL bp_reads_held: got %0d exp 12", addr_log.size() - ba); end
    checks++; if (vtx_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b exp 1", vtx_valid); end
    checks++; if (vtx_data !== exp_vtx(ADDR_W'('h200))) begin errors++; $display("FAIL bp_head: got %0h exp %0h", vtx_data, exp_vtx(ADDR_W'('h200))); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %0b exp 1", busy); end
    vtx_ready = 1'b1;
    wait_idle(400);
    checks++; if (addr_log.size() - ba !== 24) begin errors++; $display("FAIL bp_reads_total: got %0d exp 24", addr_log.size() - ba); end
    checks++; if (got_log.size() - bg !== 8) begin errors++; $display("FAIL bp_vtx_count: got %0d exp 8", got_log.size() - bg); end
    for (int v = 0; v < 8; v++) begin
      if (got_log.size() > bg + v) begin
        va = ADDR_W'('h200 + 12*v);
        checks++;
        if (got_log[bg+v] !== {(v == 7), exp_vtx(va)}) begin
          errors++; $display("FAIL bp_vtx%0d: got %0h exp %0h", v, got_log[bg+v], {(v == 7), exp_vtx(va)});
        end
      end
    end
    checks++; if (stable_viol - bs !== 0) begin errors++; $display("FAIL bp_stable: got %0d violations exp 0", stable_viol - bs); end
  endtask

  task automatic test_zero_count();
    int br = rd_cycles;
    int bv = vv_cycles;
    int bg;
    vtx_ready = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_addr  = ADDR_W'('h500);
    cmd_count = '0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %0b exp 1", cmd_ready); end
    @(negedge clock);
    cmd_valid = 1'b0;
    checks++; if (fsm_state !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_idle: got state=%0d busy=%0b exp 0 0", fsm_state, busy);
    end
    inject_rv = 1'b1;
    repeat (2) @(negedge clock);
    inject_rv = 1'b0;
    repeat (8) @(negedge clock);
    checks++; if (rd_cycles - br !== 0) begin errors++; $display("FAIL zero_reads: got %0d read cycles exp 0", rd_cycles - br); end
    checks++; if (vv_cycles - bv !== 0) begin errors++; $display("FAIL zero_valid: got %0d valid cycles exp 0", vv_cycles - bv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %0b exp 0", busy); end
    bg = got_log.size();
    send_cmd(ADDR_W'('h140), 16'd1);
    wait_idle(200);
    checks++; if (got_log.size() - bg !== 1) begin errors++; $display("FAIL stray_vtx_count: got %0d exp 1", got_log.size() - bg); end
    if (got_log.size() > bg) begin
      checks++; if (got_log[bg] !== {1'b1, exp_vtx(ADDR_W'('h140))}) begin
        errors++; $display("FAIL stray_vtx: got %0h exp %0h", got_log[bg], {1'b1, exp_vtx(ADDR_W'('h140))});
      end
    end
  endtask

  task automatic test_reset_mid();
    int ba = acc_n;
    int t = 0;
    int br, bg, bl;
    vtx_ready = 1'b1;
    send_cmd(ADDR_W'('h300), 16'd4);
    while (acc_n - ba < 4 && t < 100) begin
      @(negedge clock);
      t++;
    end
    checks++; if (acc_n - ba < 4) begin errors++; $display("FAIL mid_reads: got %0d exp 4", acc_n - ba); end
    #2 reset = 1'b0;
    #1;
    checks++; if (master_read !== 1'b0 || master_address !== '0) begin
      errors++; $display("FAIL mid_rst_bus: got read=%0b addr=%0h exp 0 0", master_read, master_address);
    end
    checks++; if (vtx_valid !== 1'b0 || vtx_data !== '0 || vtx_last !== 1'b0) begin
      errors++; $display("FAIL mid_rst_vtx: got v=%0b d=%0h l=%0b exp 0 0 0", vtx_valid, vtx_data, vtx_last);
    end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rst_ctl: got busy=%0b ready=%0b exp 0 1", busy, cmd_ready);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    br = rd_cycles;
    repeat (5) @(negedge clock);
    checks++; if (rd_cycles - br !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_no_resume: got %0d read cycles busy=%0b exp 0 0", rd_cycles - br, busy);
    end
    bl = addr_log.size();
    bg = got_log.size();
    send_cmd(ADDR_W'('h400), 16'd1);
    wait_idle(200);
    checks++; if (addr_log.size() - bl !== 3) begin errors++; $display("FAIL mid_new_reads: got %0d exp 3", addr_log.size() - bl); end
    if (addr_log.size() > bl) begin
      checks++; if (addr_log[bl] !== ADDR_W'('h400)) begin errors++; $display("FAIL mid_new_addr: got %0h exp 400", addr_log[bl]); end
    end
    checks++; if (got_log.size() - bg !== 1) begin errors++; $display("FAIL mid_new_count: got %0d exp 1", got_log.size() - bg); end
    if (got_log.size() > bg) begin
      checks++; if (got_log[bg] !== {1'b1, exp_vtx(ADDR_W'('h400))}) begin
        errors++; $display("FAIL mid_new_vtx: got %0h exp %0h", got_log[bg], {1'b1, exp_vtx(ADDR_W'('h400))});
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_stall();
    test_backpressure();
    test_zero_count();
    test_reset_mid();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
